// File: rtl/pspin_her_sched_pkg.sv
// Shared types and constants for the PsPIN HER scheduler: packed HER layout,
// default credit limit and the source-index width helper.
package pspin_her_sched_pkg;

    typedef struct packed {
        logic [15:0] msgid;
        logic        is_eom;
        logic [63:0] addr;
        logic [31:0] size;
        logic [31:0] xfer_size;
        logic [14:0] meta;
    } her_t;

    localparam int HER_WIDTH = $bits(her_t);
    localparam int HER_SCHED_DEFAULT_MAX_INFLIGHT = 8;

    // A single source still needs a 1-bit index port.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pspin_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// at N. Produces a one-hot grant, its index and an any-request flag.
module pspin_rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);
    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int off = 0; off < N; off++) begin
            k = int'(ptr) + off;
            if (k >= N) k = k - N;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = W'(k);
            end
        end
    end

endmodule

// File: rtl/pspin_her_sched.sv
// Round-robin HER merger with a global in-flight credit limit refilled by
// PsPIN completion feedback. Optional macro PSPIN_HER_SCHED_STATS_EN adds
// per-source grant counters on stat_grants.
module pspin_her_sched #(
    parameter int NUM_SRC   = 4,
    parameter int HER_WIDTH = pspin_her_sched_pkg::HER_WIDTH,
    parameter int CNT_WIDTH = 16,
    parameter int SRC_WIDTH = pspin_her_sched_pkg::src_width(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          conf_enable,
    input  logic [CNT_WIDTH-1:0]          conf_max_inflight,
    input  logic [NUM_SRC-1:0]            s_her_valid,
    output logic [NUM_SRC-1:0]            s_her_ready,
    input  logic [NUM_SRC*HER_WIDTH-1:0]  s_her_data,
    output logic                          m_her_valid,
    input  logic                          m_her_ready,
    output logic [HER_WIDTH-1:0]          m_her_data,
    output logic [SRC_WIDTH-1:0]          m_her_src,
    input  logic                          feedback_valid,
    output logic                          feedback_ready,
    output logic [CNT_WIDTH-1:0]          stat_inflight,
    output logic                          stat_underflow
`ifdef PSPIN_HER_SCHED_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]         stat_grants
`endif
);
    import pspin_her_sched_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [NUM_SRC-1:0]   arb_grant;
    logic [SRC_WIDTH-1:0] arb_idx;
    logic                 arb_any;
    logic                 load;

    logic                 m_valid_q, m_valid_d;
    logic [HER_WIDTH-1:0] m_data_q, m_data_d;
    logic [SRC_WIDTH-1:0] m_src_q, m_src_d;
    logic [SRC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic                 underflow_q, underflow_d;

    pspin_rr_arb #(
        .N (NUM_SRC),
        .W (SRC_WIDTH)
    ) u_arb (
        .req   (s_her_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Ready is suppressed while reset is held so no source sees a phantom accept.
    always_comb begin
        load = !rst && (!m_valid_q || m_her_ready) && conf_enable
               && (inflight_q < conf_max_inflight) && arb_any;

        s_her_ready = load ? arb_grant : '0;
        m_valid_d   = m_valid_q && !m_her_ready;
        m_data_d    = m_data_q;
        m_src_d     = m_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = s_her_data[int'(arb_idx)*HER_WIDTH +: HER_WIDTH];
            m_src_d   = arb_idx;
            rr_ptr_d  = (arb_idx == SRC_WIDTH'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;
        end

        // Credit is taken at grant; a coincident completion cancels it out.
        inflight_d  = inflight_q;
        underflow_d = underflow_q;
        if (load && !feedback_valid) begin
            if (inflight_q != CNT_MAX) inflight_d = inflight_q + 1'b1;
        end else if (!load && feedback_valid) begin
            if (inflight_q == '0) underflow_d = 1'b1;
            else                  inflight_d  = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_src_q     <= '0;
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_src_q     <= m_src_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            underflow_q <= underflow_d;
        end
    end

    assign m_her_valid    = m_valid_q;
    assign m_her_data     = m_data_q;
    assign m_her_src      = m_src_q;
    assign feedback_ready = 1'b1;
    assign stat_inflight  = inflight_q;
    assign stat_underflow = underflow_q;

`ifdef PSPIN_HER_SCHED_STATS_EN
    logic [NUM_SRC-1:0][31:0] grants_q, grants_d;

    always_comb begin
        grants_d = grants_q;
        if (load) grants_d[arb_idx] = grants_q[arb_idx] + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) grants_q <= '0;
        else     grants_q <= grants_d;
    end

    assign stat_grants = grants_q;
`endif

endmodule

// File: tb/tb_pspin_her_sched.sv
// Directed bench for pspin_her_sched: vector table for credit and round-robin
// behaviour, plus hand-written multi-cycle sequences.
module tb_pspin_her_sched;

    localparam int NS = 4;
    localparam int HW = 160;
    localparam int CW = 16;
    localparam int SW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               conf_enable;
    logic [CW-1:0]      conf_max_inflight;
    logic [NS-1:0]      s_her_valid;
    logic [NS-1:0]      s_her_ready;
    logic [NS*HW-1:0]   s_her_data;
    logic               m_her_valid;
    logic               m_her_ready;
    logic [HW-1:0]      m_her_data;
    logic [SW-1:0]      m_her_src;
    logic               feedback_valid;
    logic               feedback_ready;
    logic [CW-1:0]      stat_inflight;
    logic               stat_underflow;
`ifdef PSPIN_HER_SCHED_STATS_EN
    logic [NS*32-1:0]   stat_grants;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pspin_her_sched #(
        .NUM_SRC   (NS),
        .HER_WIDTH (HW),
        .CNT_WIDTH (CW),
        .SRC_WIDTH (SW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .conf_enable       (conf_enable),
        .conf_max_inflight (conf_max_inflight),
        .s_her_valid       (s_her_valid),
        .s_her_ready       (s_her_ready),
        .s_her_data        (s_her_data),
        .m_her_valid       (m_her_valid),
        .m_her_ready       (m_her_ready),
        .m_her_data        (m_her_data),
        .m_her_src         (m_her_src),
        .feedback_valid    (feedback_valid),
        .feedback_ready    (feedback_ready),
        .stat_inflight     (stat_inflight),
        .stat_underflow    (stat_underflow)
`ifdef PSPIN_HER_SCHED_STATS_EN
        ,
        .stat_grants       (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [CW-1:0] mx;
        logic [NS-1:0] sv;
        logic          mr;
        logic          fb;
        logic [NS-1:0] e_sr;
        logic          e_mv;
        logic [SW-1:0] e_src;
        logic [CW-1:0] e_inf;
        logic          e_uf;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic en, input logic [CW-1:0] mx, input logic [NS-1:0] sv,
                                input logic mr, input logic fb, input logic [NS-1:0] e_sr,
                                input logic e_mv, input logic [SW-1:0] e_src,
                                input logic [CW-1:0] e_inf, input logic e_uf);
        vec_t v;
        v.en = en; v.mx = mx; v.sv = sv; v.mr = mr; v.fb = fb;
        v.e_sr = e_sr; v.e_mv = e_mv; v.e_src = e_src; v.e_inf = e_inf; v.e_uf = e_uf;
        return v;
    endfunction

    function automatic logic [HW-1:0] pat(input int s, input int t);
        logic [31:0] w;
        w = 32'hC0DE0000 ^ (t << 8) ^ s;
        return {5{w}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_wide(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_data(input int t);
        for (int i = 0; i < NS; i++) s_her_data[i*HW +: HW] = pat(i, t);
    endtask

    task automatic idle_inputs;
        conf_enable       = 1'b0;
        conf_max_inflight = '0;
        s_her_valid       = '0;
        m_her_ready       = 1'b0;
        feedback_valid    = 1'b0;
        set_data(0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Credit exhaustion with a single source, then feedback refill and drain.
        tbl[0]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 16'd0, 1'b0);
        tbl[1]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 16'd1, 1'b0);
        tbl[2]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 16'd2, 1'b0);
        tbl[3]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 16'd3, 1'b0);
        tbl[4]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 16'd4, 1'b0);
        tbl[5]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 16'd4, 1'b0);
        tbl[6]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 16'd4, 1'b0);
        tbl[7]  = mk(1'b1, 16'd4, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 16'd3, 1'b0);
        tbl[8]  = mk(1'b1, 16'd4, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 16'd4, 1'b0);
        tbl[9]  = mk(1'b1, 16'd4, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 16'd4, 1'b0);
        tbl[10] = mk(1'b1, 16'd4, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 16'd3, 1'b0);
        tbl[11] = mk(1'b1, 16'd4, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 16'd2, 1'b0);
        tbl[12] = mk(1'b1, 16'd4, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 16'd1, 1'b0);
        tbl[13] = mk(1'b1, 16'd4, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0);
        // Round robin from pointer 1, skipping idle sources, and load+feedback.
        tbl[14] = mk(1'b1, 16'd100, 4'hF, 1'b1, 1'b0, 4'h2, 1'b0, 2'd0, 16'd0, 1'b0);
        tbl[15] = mk(1'b1, 16'd100, 4'hF, 1'b1, 1'b0, 4'h4, 1'b1, 2'd1, 16'd1, 1'b0);
        tbl[16] = mk(1'b1, 16'd100, 4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 2'd2, 16'd2, 1'b0);
        tbl[17] = mk(1'b1, 16'd100, 4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 2'd3, 16'd3, 1'b0);
        tbl[18] = mk(1'b1, 16'd100, 4'hF, 1'b1, 1'b0, 4'h2, 1'b1, 2'd0, 16'd4, 1'b0);
        tbl[19] = mk(1'b1, 16'd100, 4'h5, 1'b1, 1'b0, 4'h4, 1'b1, 2'd1, 16'd5, 1'b0);
        tbl[20] = mk(1'b1, 16'd100, 4'h5, 1'b1, 1'b0, 4'h1, 1'b1, 2'd2, 16'd6, 1'b0);
        tbl[21] = mk(1'b1, 16'd100, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 16'd7, 1'b0);
        tbl[22] = mk(1'b1, 16'd100, 4'h8, 1'b1, 1'b1, 4'h8, 1'b0, 2'd0, 16'd7, 1'b0);
        tbl[23] = mk(1'b1, 16'd100, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd3, 16'd7, 1'b0);

        rst = 1'b1;
        idle_inputs();
        #2;
        check("rst_m_valid", 32'(m_her_valid), 32'd0);
        check_wide("rst_m_data", m_her_data, '0);
        check("rst_m_src", 32'(m_her_src), 32'd0);
        check("rst_inflight", 32'(stat_inflight), 32'd0);
        check("rst_underflow", 32'(stat_underflow), 32'd0);
        check("rst_s_ready", 32'(s_her_ready), 32'd0);
        check("rst_fb_ready", 32'(feedback_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            conf_enable       = tbl[i].en;
            conf_max_inflight = tbl[i].mx;
            s_her_valid       = tbl[i].sv;
            m_her_ready       = tbl[i].mr;
            feedback_valid    = tbl[i].fb;
            #1;
            check($sformatf("v%0d_s_ready", i), 32'(s_her_ready), 32'(tbl[i].e_sr));
            check($sformatf("v%0d_m_valid", i), 32'(m_her_valid), 32'(tbl[i].e_mv));
            check($sformatf("v%0d_inflight", i), 32'(stat_inflight), 32'(tbl[i].e_inf));
            check($sformatf("v%0d_underflow", i), 32'(stat_underflow), 32'(tbl[i].e_uf));
            if (tbl[i].e_mv) begin
                check($sformatf("v%0d_m_src", i), 32'(m_her_src), 32'(tbl[i].e_src));
                check_wide($sformatf("v%0d_m_data", i), m_her_data, pat(int'(tbl[i].e_src), 0));
            end
        end

        // Backpressure: held HER stays stable while sources change their data.
        do_reset();
        @(negedge clk);
        conf_enable = 1'b1; conf_max_inflight = 16'd8; s_her_valid = 4'h1; m_her_ready = 1'b0;
        set_data(1);
        #1 check("hold_grant", 32'(s_her_ready), 32'h1);
        @(negedge clk);
        set_data(2);
        #1;
        for (int c = 0; c < 5; c++) begin
            check("hold_m_valid", 32'(m_her_valid), 32'd1);
            check_wide("hold_m_data", m_her_data, pat(0, 1));
            check("hold_s_ready", 32'(s_her_ready), 32'd0);
            check("hold_inflight", 32'(stat_inflight), 32'd1);
            @(negedge clk);
            #1;
        end
        m_her_ready = 1'b1; s_her_valid = 4'h0;
        @(negedge clk);
        #1;
        check("hold_drained", 32'(m_her_valid), 32'd0);
        check("hold_inflight_after", 32'(stat_inflight), 32'd1);

        // Load and feedback together, then drain and underflow.
        do_reset();
        @(negedge clk);
        conf_enable = 1'b1; conf_max_inflight = 16'd8; s_her_valid = 4'h1; m_her_ready = 1'b1;
        repeat (2) @(negedge clk);
        feedback_valid = 1'b1;
        #1;
        check("same_pre_inflight", 32'(stat_inflight), 32'd2);
        check("same_load", 32'(s_her_ready), 32'h1);
        @(negedge clk);
        s_her_valid = 4'h0;
        #1 check("same_inflight", 32'(stat_inflight), 32'd2);
        @(negedge clk);
        #1 check("drain_inflight1", 32'(stat_inflight), 32'd1);
        @(negedge clk);
        #1;
        check("drain_inflight0", 32'(stat_inflight), 32'd0);
        check("pre_underflow", 32'(stat_underflow), 32'd0);
        @(negedge clk);
        feedback_valid = 1'b0;
        #1;
        check("uf_inflight", 32'(stat_inflight), 32'd0);
        check("uf_flag", 32'(stat_underflow), 32'd1);
        @(negedge clk);
        #1 check("uf_sticky", 32'(stat_underflow), 32'd1);

        // Disable while a HER is held: it is still delivered, nothing new granted.
        do_reset();
        @(negedge clk);
        conf_enable = 1'b1; conf_max_inflight = 16'd8; s_her_valid = 4'h1; m_her_ready = 1'b0;
        @(negedge clk);
        conf_enable = 1'b0; m_her_ready = 1'b1;
        #1;
        check("dis_held", 32'(m_her_valid), 32'd1);
        check("dis_no_grant", 32'(s_her_ready), 32'd0);
        @(negedge clk);
        #1;
        check("dis_delivered", 32'(m_her_valid), 32'd0);
        check("dis_no_grant2", 32'(s_her_ready), 32'd0);
        check("dis_inflight", 32'(stat_inflight), 32'd1);

        // Limit lowered 8 -> 2 at inflight 5: four completions needed to resume.
        do_reset();
        @(negedge clk);
        conf_enable = 1'b1; conf_max_inflight = 16'd8; s_her_valid = 4'h1; m_her_ready = 1'b1;
        repeat (5) @(negedge clk);
        conf_max_inflight = 16'd2; feedback_valid = 1'b1;
        #1;
        check("lim_inflight5", 32'(stat_inflight), 32'd5);
        check("lim_blocked", 32'(s_her_ready), 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("lim_drain_inflight", 32'(stat_inflight), 32'(5 - k));
            check("lim_drain_blocked", 32'(s_her_ready), 32'd0);
        end
        @(negedge clk);
        feedback_valid = 1'b0;
        #1;
        check("lim_resume_inflight", 32'(stat_inflight), 32'd1);
        check("lim_resume_grant", 32'(s_her_ready), 32'h1);

        // Full-rate round robin from reset, then asynchronous reset mid-stream.
        do_reset();
        @(negedge clk);
        conf_enable = 1'b1; conf_max_inflight = 16'd100; s_her_valid = 4'hF; m_her_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 check("rr_grant", 32'(s_her_ready), 32'(1 << (c % 4)));
            @(negedge clk);
            #1;
            check("rr_m_valid", 32'(m_her_valid), 32'd1);
            check("rr_m_src", 32'(m_her_src), 32'(c % 4));
        end
        check("rr_inflight", 32'(stat_inflight), 32'd6);
`ifdef PSPIN_HER_SCHED_STATS_EN
        check_wide("stats_pre", 160'(stat_grants), 160'({32'd1, 32'd1, 32'd2, 32'd2}));
`endif
        rst = 1'b1;
        #1;
        check("arst_m_valid", 32'(m_her_valid), 32'd0);
        check_wide("arst_m_data", m_her_data, '0);
        check("arst_m_src", 32'(m_her_src), 32'd0);
        check("arst_inflight", 32'(stat_inflight), 32'd0);
        check("arst_s_ready", 32'(s_her_ready), 32'd0);
        check("arst_fb_ready", 32'(feedback_ready), 32'd1);
`ifdef PSPIN_HER_SCHED_STATS_EN
        check_wide("stats_post", 160'(stat_grants), '0);
`endif
        @(negedge clk);
        s_her_valid = 4'h0;
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
